// File: rtl/mat_pkg.sv
// Shared widths, FSM state and slot addressing for the 4x4 matrix datapath.
// Used by the loader, the multiplier and the result stage.
package mat_pkg;

  localparam int DATA_W = 16;
  localparam int DIM    = 4;
  localparam int MAT_W  = DIM * DIM * DATA_W;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  // MSB of row-major element n in a packed matrix bus
  function automatic int slot_msb(input logic [3:0] n);
    return MAT_W - 1 - DATA_W * int'(n);
  endfunction

endpackage

// File: rtl/mat_pair_loader_if.sv
// Element stream in, packed matrix pair out, for mat_pair_loader.
// Master is the producer/consumer side, slave is the loader.
interface mat_pair_loader_if;
  import mat_pkg::*;

  logic [DATA_W-1:0] elem_data;
  logic              elem_valid;
  logic              elem_ready;
  logic              elem_last;
  logic [MAT_W-1:0]  mat_a;
  logic [MAT_W-1:0]  mat_b;
  logic              mat_valid;
  logic              mat_ready;
  logic              frame_err;

  modport master (
    output elem_data, elem_valid, elem_last, mat_ready,
    input  elem_ready, mat_a, mat_b, mat_valid, frame_err
  );

  modport slave (
    input  elem_data, elem_valid, elem_last, mat_ready,
    output elem_ready, mat_a, mat_b, mat_valid, frame_err
  );

endinterface

// File: rtl/mat_pair_loader.sv
// Packs a 32-element stream into matrices A and B and holds the pair.
// MAT_FRAME_CHECK_EN enables elem_last framing check and frame_err.
module mat_pair_loader #(
  parameter int DATA_W = mat_pkg::DATA_W,
  parameter int DIM    = mat_pkg::DIM
) (
  input logic         clk,
  input logic         rst,
  mat_pair_loader_if.slave bus
);
  import mat_pkg::*;

  localparam int MAT_W = DIM * DIM * DATA_W;

  if (DIM != 4 || MAT_W != mat_pkg::MAT_W) begin : g_bad_dim
    $error("mat_pair_loader: only DIM=4, DATA_W=16 supported");
  end

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [MAT_W-1:0] a_q, b_q;
  logic             xfer, bad;
  logic             we_a, we_b;
  logic             err_d, err_q;

  assign xfer           = bus.elem_valid && bus.elem_ready;
  assign bus.elem_ready = (state_q != HOLD);
  assign bus.mat_valid  = (state_q == HOLD);
  assign bus.mat_a      = a_q;
  assign bus.mat_b      = b_q;
  assign bus.frame_err  = err_q;

`ifdef MAT_FRAME_CHECK_EN
  assign bad = xfer &&
    (bus.elem_last != (state_q == LOAD_B && cnt_q == 4'd15));
`else
  logic unused_last;
  assign unused_last = bus.elem_last;
  assign bad = 1'b0;
`endif

  // State, counter and error pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state: count transfers, drop the pair on a framing error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD_A, LOAD_B: begin
        if (bad) begin
          err_d   = 1'b1;
          state_d = LOAD_A;
          cnt_d   = 4'd0;
        end else if (xfer) begin
          we_a  = (state_q == LOAD_A);
          we_b  = (state_q == LOAD_B);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15)
            state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
        end
      end
      HOLD: begin
        if (bus.mat_ready) begin
          state_d = LOAD_A;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Packing registers, written one slot per accepted element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (we_a) a_q[slot_msb(cnt_q) -: DATA_W] <= bus.elem_data;
      if (we_b) b_q[slot_msb(cnt_q) -: DATA_W] <= bus.elem_data;
    end
  end

endmodule

// File: tb/tb_mat_pair_loader.sv
// Directed bench for mat_pair_loader.
// Build with +define+MAT_FRAME_CHECK_EN to cover the framing check.
module tb_mat_pair_loader;
  import mat_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mat_pair_loader_if bus();

  mat_pair_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  localparam logic [255:0] A_SEQ =
    256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
  localparam logic [255:0] B_ID =
    256'h0001_0000_0000_0000_0000_0001_0000_0000_0000_0000_0001_0000_0000_0000_0000_0001;
  localparam logic [255:0] A_SGN =
    256'h8000_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_ffff;
  localparam logic [255:0] B_REP =
    256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    bus.elem_data  = d;
    bus.elem_last  = l;
    bus.elem_valid = 1'b1;
    while (!bus.elem_ready && t < 100) begin
      tick();
      t++;
    end
    check("ready_wait", 256'(t < 100), 256'(1));
    tick();
    bus.elem_valid = 1'b0;
    bus.elem_last  = 1'b0;
  endtask

  task automatic send_range(input logic [255:0] a,
                            input logic [255:0] b,
                            input int lo, input int hi,
                            input int maxgap);
    logic [255:0] m;
    logic [15:0]  d;
    for (int n = lo; n <= hi; n++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      m = (n < 16) ? a : b;
      d = m[255 - 16 * (n % 16) -: 16];
      send(d, n == 31);
    end
  endtask

  task automatic pulse_ready();
    bus.mat_ready = 1'b1;
    tick();
    bus.mat_ready = 1'b0;
  endtask

  initial begin
    bus.elem_data  = '0;
    bus.elem_valid = 1'b0;
    bus.elem_last  = 1'b0;
    bus.mat_ready  = 1'b0;

    #12;
    check("rst_mat_a", bus.mat_a, '0);
    check("rst_mat_b", bus.mat_b, '0);
    check("rst_valid", 256'(bus.mat_valid), 256'(0));
    check("rst_ferr", 256'(bus.frame_err), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_ready", 256'(bus.elem_ready), 256'(1));

    send_range(A_SEQ, B_ID, 0, 30, 0);
    check("p1_valid_31", 256'(bus.mat_valid), 256'(0));
    send_range(A_SEQ, B_ID, 31, 31, 0);
    check("p1_valid", 256'(bus.mat_valid), 256'(1));
    check("p1_ready", 256'(bus.elem_ready), 256'(0));
    check("p1_mat_a", bus.mat_a, A_SEQ);
    check("p1_mat_b", bus.mat_b, B_ID);

    for (int i = 0; i < 10; i++) begin
      bus.elem_valid = 1'b1;
      bus.elem_data  = 16'hdead;
      tick();
      check("hold_a", bus.mat_a, A_SEQ);
      check("hold_b", bus.mat_b, B_ID);
      check("hold_valid", 256'(bus.mat_valid), 256'(1));
    end
    bus.elem_valid = 1'b0;
    pulse_ready();
    check("rel_valid", 256'(bus.mat_valid), 256'(0));
    check("rel_ready", 256'(bus.elem_ready), 256'(1));
    check("rel_keep_a", bus.mat_a, A_SEQ);

    send_range(A_SGN, B_REP, 0, 31, 3);
    check("p2_valid", 256'(bus.mat_valid), 256'(1));
    check("p2_mat_a", bus.mat_a, A_SGN);
    check("p2_mat_b", bus.mat_b, B_REP);
    check("p2_msb", 256'(bus.mat_a[255:240]), 256'(16'h8000));
    check("p2_lsb", 256'(bus.mat_a[15:0]), 256'(16'hffff));
    check("p2_s14", 256'(bus.mat_a[31:16]), 256'(16'h000f));

    bus.mat_ready = 1'b1;
    tick();
    check("p2_rel", 256'(bus.mat_valid), 256'(0));
    send_range(B_REP, A_SEQ, 0, 30, 1);
    check("p3_valid_31", 256'(bus.mat_valid), 256'(0));
    send_range(B_REP, A_SEQ, 31, 31, 0);
    check("p3_valid", 256'(bus.mat_valid), 256'(1));
    check("p3_mat_a", bus.mat_a, B_REP);
    check("p3_mat_b", bus.mat_b, A_SEQ);
    tick();
    check("p3_hold1", 256'(bus.mat_valid), 256'(0));
    check("p3_ready", 256'(bus.elem_ready), 256'(1));
    bus.mat_ready = 1'b0;

    send_range(A_SEQ, B_ID, 0, 19, 0);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_a", bus.mat_a, '0);
    check("mrst_b", bus.mat_b, '0);
    check("mrst_valid", 256'(bus.mat_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_range(A_SEQ, B_ID, 0, 30, 0);
    check("p4_valid_31", 256'(bus.mat_valid), 256'(0));
    send_range(A_SEQ, B_ID, 31, 31, 0);
    check("p4_valid", 256'(bus.mat_valid), 256'(1));
    check("p4_mat_a", bus.mat_a, A_SEQ);
    check("p4_mat_b", bus.mat_b, B_ID);
    pulse_ready();

`ifdef MAT_FRAME_CHECK_EN
    for (int i = 0; i < 10; i++) send(16'(i + 1), i == 9);
    check("fe_pulse", 256'(bus.frame_err), 256'(1));
    check("fe_valid", 256'(bus.mat_valid), 256'(0));
    check("fe_ready", 256'(bus.elem_ready), 256'(1));
    tick();
    check("fe_one", 256'(bus.frame_err), 256'(0));
    send_range(A_SGN, B_REP, 0, 30, 0);
    check("fe_valid_31", 256'(bus.mat_valid), 256'(0));
    check("fe_quiet", 256'(bus.frame_err), 256'(0));
    send_range(A_SGN, B_REP, 31, 31, 0);
    check("fe_p_valid", 256'(bus.mat_valid), 256'(1));
    check("fe_p_err", 256'(bus.frame_err), 256'(0));
    check("fe_p_a", bus.mat_a, A_SGN);
    check("fe_p_b", bus.mat_b, B_REP);
`else
    check("ferr_tied", 256'(bus.frame_err), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
